pattern_bank: RTL and testbench
===============================

Name: pattern_bank

Overview:
- Parametrised bank of NO_BUFS pattern buffers. Each buffer holds BUFFER_SIZE bytes of BUFFER_WIDTH bits.
- Supports three access paths:
  - Registered whole-buffer selection onto current_buffer.
  - Registered single-byte field read and a single-byte field write.
  - Serial scan load through a shared shadow register, committed atomically to the target buffer only after a complete frame.
- Sits between the scan/config interface and the pattern processor datapath. Replaces the fixed 8×22×8 bank.

Parameters:
- NO_BUFS, 8, number of buffers (2..16).
- BUFFER_SIZE, 22, bytes per buffer.
- BUFFER_WIDTH, 8, bits per byte.
- SADDR_W, $clog2(NO_BUFS), derived; width of saddr.
- FRAME_LEN, BUFFER_SIZE*BUFFER_WIDTH, derived; scan bits per frame (176 at defaults).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- sin  in  1  serial scan data.
- ssel  in  1  scan enable; a rising edge starts a load.
- saddr  in  SADDR_W  target buffer for scan, sampled at load start.
- sout  out  1  serial scan-out.
- load_busy  out  1  high while a scan load is in progress.
- load_done  out  1  one-cycle pulse on commit.
- load_abort  out  1  one-cycle pulse on incomplete frame.
- sel_error  out  1  one-cycle pulse on any illegal select.
- buffer_select  in  NO_BUFS  one-hot buffer for current_buffer.
- current_buffer  out  FRAME_LEN  flattened; byte k at [k*BUFFER_WIDTH +: BUFFER_WIDTH].
- bufp  in  NO_BUFS  one-hot buffer for field read/write.
- fieldp  in  BUFFER_SIZE  one-hot byte for field read.
- field_byte  out  BUFFER_WIDTH  registered read byte.
- fieldwp  in  BUFFER_SIZE  one-hot byte for field write.
- field_in  in  BUFFER_WIDTH  write data.
- field_write  in  1  write strobe.

Behaviour:
- Reset: all buffers, shadow, current_buffer, field_byte, sout, load_busy, load_done, load_abort and sel_error are 0. FSM goes to IDLE. Reset in mid-load discards the shadow, and no commit occurs.
- current_buffer:
  - Valid one-hot buffer_select: buffer[sel] is registered, giving 1-cycle latency.
  - Non-one-hot buffer_select: holds its previous value and pulses sel_error.
- field_byte:
  - Valid one-hot bufp and one-hot fieldp: buffer[bufp][fieldp] is registered, giving 1-cycle latency.
  - Otherwise: drives 0 and pulses sel_error.
- Field write: when field_write=1 with one-hot bufp and one-hot fieldwp, buffer[bufp][fieldwp] <= field_in at the next edge. An illegal select drops the write and pulses sel_error.
- Read-during-write to the same byte returns the old value.
- Scan FSM states: IDLE, SHIFT, COMMIT.
  - IDLE:
    - sout = MSB of buffer[saddr]; 0 if saddr ≥ NO_BUFS.
    - Start condition: ssel=1 and ssel was 0 the previous cycle.
    - On start with saddr<NO_BUFS: latch target=saddr; shadow <= {buffer[saddr][FRAME_LEN-2:0], sin}; count=1; go to SHIFT.
    - On start with saddr ≥ NO_BUFS: pulse sel_error and stay in IDLE.
  - SHIFT:
    - While ssel=1: shadow <= {shadow[FRAME_LEN-2:0], sin}; count++; sout = shadow MSB. Old contents therefore stream out MSB-first as new bits stream in.
    - When the FRAME_LEN-th bit is shifted, go to COMMIT.
    - If ssel=0 before then: pulse load_abort, return to IDLE, leave the buffer unchanged.
  - COMMIT: buffer[target] <= shadow; pulse load_done; go to IDLE.
    - ssel during COMMIT is ignored.
    - A new load needs ssel to fall, then rise again.
- load_busy = (state != IDLE).
- A field write to target during SHIFT is applied, then overwritten by the commit.
- A field write to target in the COMMIT cycle is dropped; commit wins.
- Scan bit order: the first sin bit lands in byte BUFFER_SIZE-1 bit BUFFER_WIDTH-1; the last lands in byte 0 bit 0.

Decomposition:
- Shared package pattern_bank_pkg holds:
  - scan_state_t enum (IDLE, SHIFT, COMMIT).
  - is_onehot() function.
  - onehot_to_idx() function.
  - Derived-width localparams.
- Sub-module pattern_slot is instantiated NO_BUFS times. Each instance holds one buffer's storage with a byte write port (we, byte one-hot, data) and a full-frame commit port, with commit taking priority.

Test Plan:
- Reset then idle: buffer_select=8'h01 → current_buffer=0 after 1 cycle; all pulses 0.
- Field write/read: bufp=8'h04, fieldwp=bit3, field_in=8'hA5, write → one cycle later fieldp=bit3 → field_byte=8'hA5 after 1 cycle; other buffers unchanged.
- Full scan load:
  - Stimulus: saddr=5, ssel high 176 cycles shifting pattern 8'h3C per byte.
  - Required: load_busy high throughout; load_done pulse 1 cycle after the last bit; buffer 5 all bytes 8'h3C.
  - Required: sout replays the prior buffer 5 contents MSB-first.
- Abort: ssel dropped after 100 bits → load_abort pulse, buffer unchanged, no load_done.
- Conflicts:
  - Field write to the target in the COMMIT cycle → commit value wins.
  - buffer_select=8'h03 → sel_error pulse, current_buffer holds.
  - saddr=7 with NO_BUFS=6 → sel_error, no load.
- Reset mid-SHIFT: after bit 50 assert reset → FSM IDLE, load_busy=0, all buffers 0, no load_done.

Source files
------------

// File: rtl/pattern_bank_pkg.sv
// Shared types and select-decoding helpers for the pattern buffer bank.
// One-hot helpers operate on a fixed-width vector; callers zero-extend narrower selects.
package pattern_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } scan_state_t;

  localparam int ONEHOT_W = 32;
  localparam int IDX_W    = $clog2(ONEHOT_W);

  localparam int DEFAULT_NO_BUFS      = 8;
  localparam int DEFAULT_BUFFER_SIZE  = 22;
  localparam int DEFAULT_BUFFER_WIDTH = 8;

  function automatic logic is_onehot(input logic [ONEHOT_W-1:0] v);
    return (v != '0) && ((v & (v - ONEHOT_W'(1))) == '0);
  endfunction

  // OR of the indices of all set bits; exact only when v is one-hot.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [ONEHOT_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ONEHOT_W; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pattern_slot.sv
// Storage for one pattern buffer: byte-granular write port plus a full-frame
// commit port used by the scan loader; a commit overrides a same-cycle byte write.
module pattern_slot
  import pattern_bank_pkg::*;
#(
  parameter int BUFFER_SIZE  = DEFAULT_BUFFER_SIZE,
  parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH,
  parameter int FRAME_LEN    = BUFFER_SIZE * BUFFER_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [BUFFER_SIZE-1:0]  byte_sel,
  input  logic [BUFFER_WIDTH-1:0] wdata,
  input  logic                    commit,
  input  logic [FRAME_LEN-1:0]    commit_data,
  output logic [FRAME_LEN-1:0]    data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (commit) begin
      data <= commit_data;
    end else if (we) begin
      for (int k = 0; k < BUFFER_SIZE; k++) begin
        if (byte_sel[k]) data[k*BUFFER_WIDTH +: BUFFER_WIDTH] <= wdata;
      end
    end
  end

endmodule

// File: rtl/pattern_bank.sv
// Bank of NO_BUFS pattern buffers with registered whole-buffer and byte reads,
// a byte write port, and an atomic serial scan loader through a shared shadow.
module pattern_bank
  import pattern_bank_pkg::*;
#(
  parameter int NO_BUFS      = DEFAULT_NO_BUFS,
  parameter int BUFFER_SIZE  = DEFAULT_BUFFER_SIZE,
  parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH,
  parameter int SADDR_W      = $clog2(NO_BUFS),
  parameter int FRAME_LEN    = BUFFER_SIZE * BUFFER_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sin,
  input  logic                    ssel,
  input  logic [SADDR_W-1:0]      saddr,
  output logic                    sout,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_abort,
  output logic                    sel_error,
  input  logic [NO_BUFS-1:0]      buffer_select,
  output logic [FRAME_LEN-1:0]    current_buffer,
  input  logic [NO_BUFS-1:0]      bufp,
  input  logic [BUFFER_SIZE-1:0]  fieldp,
  output logic [BUFFER_WIDTH-1:0] field_byte,
  input  logic [BUFFER_SIZE-1:0]  fieldwp,
  input  logic [BUFFER_WIDTH-1:0] field_in,
  input  logic                    field_write
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic [FRAME_LEN-1:0] buf_q [NO_BUFS];
  logic [NO_BUFS-1:0]   slot_we;
  logic [NO_BUFS-1:0]   slot_commit;

  scan_state_t          state;
  logic [SADDR_W-1:0]   target;
  logic [FRAME_LEN-1:0] shadow;
  logic [CNT_W-1:0]     count;
  logic                 ssel_q;

  logic                    cur_sel_ok;
  logic                    rd_sel_ok;
  logic                    wr_sel_ok;
  logic                    saddr_ok;
  logic                    scan_start;
  logic [SADDR_W-1:0]      cur_idx;
  logic [FRAME_LEN-1:0]    rd_frame;
  logic [BUFFER_WIDTH-1:0] rd_byte;

  always_comb begin
    cur_sel_ok = is_onehot(ONEHOT_W'(buffer_select));
    rd_sel_ok  = is_onehot(ONEHOT_W'(bufp)) && is_onehot(ONEHOT_W'(fieldp));
    wr_sel_ok  = is_onehot(ONEHOT_W'(bufp)) && is_onehot(ONEHOT_W'(fieldwp));
    cur_idx    = SADDR_W'(onehot_to_idx(ONEHOT_W'(buffer_select)));
    saddr_ok   = int'(saddr) < NO_BUFS;
    scan_start = ssel && !ssel_q;
  end

  // AND-OR muxes keep non-one-hot selects from indexing outside the bank.
  always_comb begin
    rd_frame = '0;
    for (int i = 0; i < NO_BUFS; i++) begin
      if (bufp[i]) rd_frame = rd_frame | buf_q[i];
    end
    rd_byte = '0;
    for (int k = 0; k < BUFFER_SIZE; k++) begin
      if (fieldp[k]) rd_byte = rd_byte | rd_frame[k*BUFFER_WIDTH +: BUFFER_WIDTH];
    end
  end

  always_comb begin
    for (int i = 0; i < NO_BUFS; i++) begin
      slot_we[i]     = field_write && wr_sel_ok && bufp[i];
      slot_commit[i] = (state == COMMIT) && (int'(target) == i);
    end
  end

  for (genvar g = 0; g < NO_BUFS; g++) begin : g_slot
    pattern_slot #(
      .BUFFER_SIZE  (BUFFER_SIZE),
      .BUFFER_WIDTH (BUFFER_WIDTH),
      .FRAME_LEN    (FRAME_LEN)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .we          (slot_we[g]),
      .byte_sel    (fieldwp),
      .wdata       (field_in),
      .commit      (slot_commit[g]),
      .commit_data (shadow),
      .data        (buf_q[g])
    );
  end

  // Read ports and error reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      current_buffer <= '0;
      field_byte     <= '0;
      sel_error      <= 1'b0;
    end else begin
      if (cur_sel_ok) current_buffer <= buf_q[cur_idx];
      field_byte <= rd_sel_ok ? rd_byte : '0;
      sel_error  <= !cur_sel_ok || !rd_sel_ok || (field_write && !wr_sel_ok) ||
                    ((state == IDLE) && scan_start && !saddr_ok);
    end
  end

  // Scan loader: the shadow starts as the target's contents so old bits
  // stream out of sout while new bits stream in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      target     <= '0;
      shadow     <= '0;
      count      <= '0;
      ssel_q     <= 1'b0;
      sout       <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      load_abort <= 1'b0;
    end else begin
      ssel_q     <= ssel;
      load_done  <= 1'b0;
      load_abort <= 1'b0;
      case (state)
        IDLE: begin
          sout <= saddr_ok ? buf_q[saddr][FRAME_LEN-1] : 1'b0;
          if (scan_start && saddr_ok) begin
            target    <= saddr;
            shadow    <= {buf_q[saddr][FRAME_LEN-2:0], sin};
            count     <= CNT_W'(1);
            state     <= SHIFT;
            load_busy <= 1'b1;
          end
        end
        SHIFT: begin
          sout <= shadow[FRAME_LEN-1];
          if (ssel) begin
            shadow <= {shadow[FRAME_LEN-2:0], sin};
            count  <= count + CNT_W'(1);
            if (count == CNT_W'(FRAME_LEN - 1)) state <= COMMIT;
          end else begin
            load_abort <= 1'b1;
            state      <= IDLE;
            load_busy  <= 1'b0;
          end
        end
        COMMIT: begin
          sout      <= shadow[FRAME_LEN-1];
          load_done <= 1'b1;
          state     <= IDLE;
          load_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          load_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_bank.sv
// Randomised scoreboard bench for pattern_bank against a byte-array reference model.
module tb_pattern_bank;

  localparam int NB = 6;
  localparam int BS = 22;
  localparam int BW = 8;
  localparam int SW = 3;
  localparam int FL = BS * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sin = 1'b0;
  logic          ssel = 1'b0;
  logic [SW-1:0] saddr = '0;
  logic [NB-1:0] buffer_select = NB'(1);
  logic [NB-1:0] bufp = NB'(1);
  logic [BS-1:0] fieldp = BS'(1);
  logic [BS-1:0] fieldwp = BS'(1);
  logic [BW-1:0] field_in = '0;
  logic          field_write = 1'b0;

  logic          sout, load_busy, load_done, load_abort, sel_error;
  logic [FL-1:0] current_buffer;
  logic [BW-1:0] field_byte;

  pattern_bank #(
    .NO_BUFS      (NB),
    .BUFFER_SIZE  (BS),
    .BUFFER_WIDTH (BW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sin            (sin),
    .ssel           (ssel),
    .saddr          (saddr),
    .sout           (sout),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_abort     (load_abort),
    .sel_error      (sel_error),
    .buffer_select  (buffer_select),
    .current_buffer (current_buffer),
    .bufp           (bufp),
    .fieldp         (fieldp),
    .field_byte     (field_byte),
    .fieldwp        (fieldwp),
    .field_in       (field_in),
    .field_write    (field_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FL-1:0] cur;
    logic [BW-1:0] fb;
    logic          so;
    bit            chk_so;
    logic          busy;
    logic          done;
    logic          abort;
    logic          err;
  } exp_t;

  exp_t sbq [$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: buffers as byte arrays, loads as bit lists.
  logic [BW-1:0] mem [NB][BS];
  logic [FL-1:0] m_cur = '0;
  logic [BW-1:0] m_fb = '0;
  logic [FL-1:0] old_frame, new_frame;
  bit            loading = 0, committing = 0, prev_ssel = 0;
  int            nbits = 0, tgt = 0;

  function automatic bit oh(input logic [31:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic int ix(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [FL-1:0] frame_of(input int b);
    logic [FL-1:0] f;
    for (int k = 0; k < BS; k++) f[k*BW +: BW] = mem[b][k];
    return f;
  endfunction

  task automatic chk(input string name, input logic [FL-1:0] act, input logic [FL-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("current_buffer", current_buffer, mon_e.cur);
      chk("field_byte", FL'(field_byte), FL'(mon_e.fb));
      chk("load_busy", FL'(load_busy), FL'(mon_e.busy));
      chk("load_done", FL'(load_done), FL'(mon_e.done));
      chk("load_abort", FL'(load_abort), FL'(mon_e.abort));
      chk("sel_error", FL'(sel_error), FL'(mon_e.err));
      if (mon_e.chk_so) chk("sout", FL'(sout), FL'(mon_e.so));
    end
  end

  // Advance the model by one clock with the inputs now driven, queue the
  // expected outputs, and wait for the next negative edge.
  task automatic step();
    exp_t e;
    bit   err, do_commit;
    e.chk_so = 1; e.done = 0; e.abort = 0; e.so = 0;
    err = 0; do_commit = 0;
    if (reset) begin
      foreach (mem[b, k]) mem[b][k] = '0;
      m_cur = '0; m_fb = '0;
      loading = 0; committing = 0; prev_ssel = 0;
      e.busy = 0;
    end else begin
      if (oh(32'(buffer_select))) m_cur = frame_of(ix(32'(buffer_select)));
      else err = 1;
      if (oh(32'(bufp)) && oh(32'(fieldp))) m_fb = mem[ix(32'(bufp))][ix(32'(fieldp))];
      else begin m_fb = '0; err = 1; end
      if (field_write && !(oh(32'(bufp)) && oh(32'(fieldwp)))) err = 1;
      if (committing) begin
        committing = 0; do_commit = 1; e.done = 1; e.chk_so = 0;
      end else if (loading) begin
        if (ssel) begin
          e.so = old_frame[FL-1-nbits];
          new_frame[FL-1-nbits] = sin;
          nbits++;
          if (nbits == FL) begin loading = 0; committing = 1; end
        end else begin
          loading = 0; e.abort = 1; e.chk_so = 0;
        end
      end else begin
        if (ssel && !prev_ssel && int'(saddr) < NB) begin
          old_frame = frame_of(int'(saddr));
          tgt = int'(saddr);
          new_frame = '0;
          new_frame[FL-1] = sin;
          nbits = 1;
          loading = 1;
          e.so = old_frame[FL-1];
        end else begin
          if (ssel && !prev_ssel) err = 1;
          e.so = (int'(saddr) < NB) ? mem[int'(saddr)][BS-1][BW-1] : 1'b0;
        end
      end
      if (field_write && oh(32'(bufp)) && oh(32'(fieldwp)))
        mem[ix(32'(bufp))][ix(32'(fieldwp))] = field_in;
      if (do_commit)
        for (int k = 0; k < BS; k++) mem[tgt][k] = new_frame[k*BW +: BW];
      prev_ssel = ssel;
      e.busy = loading || committing;
    end
    e.cur = m_cur; e.fb = m_fb; e.err = err;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic rand_reads();
    buffer_select = NB'(1) << $urandom_range(0, NB - 1);
    bufp          = NB'(1) << $urandom_range(0, NB - 1);
    fieldp        = BS'(1) << $urandom_range(0, BS - 1);
    field_write   = 1'b0;
  endtask

  task automatic rand_load_bits(input int b, input int count, input int wr_at);
    saddr = SW'(b);
    ssel  = 1'b1;
    for (int n = 0; n < count; n++) begin
      rand_reads();
      sin = 1'($urandom);
      if (n == wr_at) begin
        bufp = NB'(1) << b; fieldwp = BS'(1) << 7; field_in = 8'h5A; field_write = 1'b1;
      end
      step();
    end
    field_write = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] pat;
    pat = 8'h3C;

    repeat (3) step();
    reset = 1'b0;
    step(); step();

    // Directed byte write then read back
    bufp = NB'(4); fieldwp = BS'(1) << 3; field_in = 8'hA5; field_write = 1'b1; step();
    field_write = 1'b0; fieldp = BS'(1) << 3; step(); step();

    repeat (80) begin
      rand_reads();
      field_write = 1'($urandom);
      fieldwp     = BS'(1) << $urandom_range(0, BS - 1);
      field_in    = BW'($urandom);
      step();
    end
    for (int k = 0; k < BS; k++) begin
      bufp = NB'(1) << 5; fieldwp = BS'(1) << k; field_in = BW'($urandom); field_write = 1'b1;
      step();
    end
    field_write = 1'b0;

    // Full load of buffer 5 with 8'h3C in every byte; ssel held through commit
    ssel = 1'b0; step();
    saddr = SW'(5); ssel = 1'b1;
    for (int n = 0; n < FL; n++) begin
      rand_reads();
      sin = pat[(FL - 1 - n) % BW];
      step();
    end
    step(); step();
    ssel = 1'b0; buffer_select = NB'(1) << 5; step(); step();
    for (int k = 0; k < BS; k++) begin
      bufp = NB'(1) << 5; fieldp = BS'(1) << k; step();
    end

    // Random load of buffer 2: write during shift, then write during commit
    rand_load_bits(2, FL, 60);
    ssel = 1'b0; bufp = NB'(4); fieldwp = BS'(1); field_in = 8'hFF; field_write = 1'b1; step();
    field_write = 1'b0; buffer_select = NB'(4); step(); step();

    // Abort after 100 bits
    rand_load_bits(1, 100, -1);
    ssel = 1'b0; step();
    buffer_select = NB'(2); step(); step();

    // Illegal selects
    buffer_select = NB'(3); step();
    buffer_select = NB'(0); step();
    buffer_select = NB'(1); bufp = NB'(0); step();
    bufp = NB'(1); fieldp = BS'(3); step();
    fieldp = BS'(1); fieldwp = BS'(0); field_write = 1'b1; step();
    field_write = 1'b0; saddr = SW'(7); ssel = 1'b1; step(); step();
    ssel = 1'b0; step(); step();

    // Random soak with occasional illegal selects and short scan bursts
    repeat (400) begin
      rand_reads();
      if ($urandom_range(0, 9) == 0) buffer_select = NB'($urandom);
      if ($urandom_range(0, 9) == 0) bufp = NB'($urandom);
      if ($urandom_range(0, 9) == 0) fieldp = BS'($urandom);
      fieldwp = ($urandom_range(0, 9) == 0) ? BS'($urandom) : BS'(1) << $urandom_range(0, BS - 1);
      field_write = 1'($urandom);
      field_in = BW'($urandom);
      if ($urandom_range(0, 19) == 0) ssel = ~ssel;
      saddr = SW'($urandom);
      sin = 1'($urandom);
      step();
    end

    // Reset during a shift discards the load and clears every buffer
    ssel = 1'b0; field_write = 1'b0; rand_reads(); step();
    rand_load_bits(3, 50, -1);
    reset = 1'b1; ssel = 1'b0; step();
    reset = 1'b0;
    for (int b = 0; b < NB; b++) begin
      buffer_select = NB'(1) << b; step();
    end
    repeat (3) step();

    repeat (4) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
